sdram_ch_arbiter: RTL and testbench
===================================

Name: sdram_ch_arbiter

Overview:
Shares one sdram controller channel (req/we/address/data_write/wm → ack/data_read) between NUM_CLI clients. Per-client command slots capture one-cycle request pulses. A round-robin FSM issues one transaction at a time to the channel and routes the ack and read data back to the owning client. Sits between client blocks (mapper, loader, CPU bridge) and one chN port of the sdram controller.

Parameters:
NUM_CLI, 3, number of clients (2..8)
ADDR_BITS, 24, word address width
DATA_BITS, 16, data width; write mask width is DATA_BITS/8

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
cli_req  in  NUM_CLI  one-cycle request pulse per client
cli_we  in  NUM_CLI  1=write, 0=read; sampled with cli_req
cli_addr  in  NUM_CLI*ADDR_BITS  packed addresses; client i at [i*ADDR_BITS +: ADDR_BITS]
cli_wdata  in  NUM_CLI*DATA_BITS  packed write data
cli_wm  in  NUM_CLI*DATA_BITS/8  packed byte write masks
cli_ack  out  NUM_CLI  one-cycle completion pulse per client
cli_rdata  out  DATA_BITS  read data, valid in the cli_ack cycle
cli_busy  out  NUM_CLI  slot i pending or in flight
mem_req  out  1  one-cycle request to the controller channel
mem_we  out  1  registered command fields
mem_addr  out  ADDR_BITS
mem_wdata  out  DATA_BITS
mem_wm  out  DATA_BITS/8
mem_ack  in  1  controller completion pulse
mem_rdata  in  DATA_BITS  controller read data, valid with mem_ack

Behaviour:
- Reset (reset=0, async): pending=0, state=IDLE, last_grant=NUM_CLI-1, and mem_req, mem_we, mem_addr, mem_wdata, mem_wm, cli_ack, cli_rdata = 0. cli_busy=0.
- Capture: at an edge with cli_req[i]=1 and pending[i]=0, slot i stores we/addr/wdata/wm and sets pending[i]. If pending[i]=1, the request is dropped. Exception: a request in the same edge as client i's completion is accepted.
- cli_busy[i] = pending[i] (combinational from the register).
- FSM states: IDLE, WAIT.
- IDLE: if any pending bit is set, select g = first pending index searching (last_grant+1) mod NUM_CLI upward with wrap. At that edge: register mem_* from slot g, set mem_req=1 for exactly one cycle, latch grant=g, go to WAIT.
- WAIT: mem_req=0. On an edge with mem_ack=1: cli_ack[g]=1 for one cycle, cli_rdata<=mem_rdata, pending[g] cleared unless re-captured the same edge, last_grant<=g, go to IDLE.
- Latency: cli_req edge E → mem_req high after E+1 at minimum. mem_ack edge A → cli_ack high after A. Next grant no earlier than edge A+1.
- Back-to-back: one transaction outstanding. Other clients' requests captured during WAIT are held.
- mem_ack in IDLE is ignored.
- cli_rdata holds its value until the next ack. It is updated on write acks too, with the value don't-care.
- Reset mid-transaction: the in-flight transaction is abandoned and no cli_ack is produced. A stray mem_ack after reset is ignored via the IDLE rule.
- Fairness: with all clients continuously re-requesting, each client is granted once per NUM_CLI grants.

Optional Feature:
SDRAM_ARB_PRIO_EN
- Defined: client 0 is high priority. If pending[0] in IDLE, it is granted regardless of last_grant. Clients 1..NUM_CLI-1 round-robin among themselves, and last_grant updates only for those clients.
- Undefined: pure round-robin over all clients.

Test Plan:
1. Client 1 write addr 0x000010, wdata 0xBEEF, wm 2'b00 → mem_req one cycle later with matching fields and mem_we=1. Bench mem_ack → cli_ack=3'b010 for one cycle. cli_busy[1] high from capture until ack.
2. After reset, clients 0,1,2 pulse together → grants 0,1,2. Repeat all three → 0,1,2. Then clients 1,2 pulse with last_grant=2 → 1,2. Mid-wait pulse of client 0 with last_grant=1 → order 2 then 0.
3. Client 2 read addr 0xFFFFFF, mem_rdata=0xF7F8 with mem_ack → cli_ack[2] with cli_rdata=0xF7F8. A prior write of 0xA7F8 by client 0 leaves cli_rdata unaffected in test assertion order.
4. Client 0 req addr 0x000001, then req addr 0x000002 before ack → only 0x000001 issued, exactly one cli_ack[0]. A req on the ack edge with addr 0x000003 → second transaction to 0x000003.
5. Assert reset in WAIT after mem_req for client 1 → all outputs 0. Release reset, then drive mem_ack → no cli_ack. A new client 1 request is served normally.
6. SDRAM_ARB_PRIO_EN defined: client 0 re-requests on every ack while clients 1,2 pending → client 0 granted every time. Stop client 0 → 1 then 2. Undefined: same stimulus → 0,1,2 interleave.

Source files
------------

// File: rtl/sdram_ch_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller channel among NUM_CLI clients.
// Optional `SDRAM_ARB_PRIO_EN: client 0 always wins; clients 1..NUM_CLI-1 rotate.
module sdram_ch_arbiter #(
  parameter int unsigned NUM_CLI   = 3,
  parameter int unsigned ADDR_BITS = 24,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CLI-1:0]             cli_req,
  input  logic [NUM_CLI-1:0]             cli_we,
  input  logic [NUM_CLI*ADDR_BITS-1:0]   cli_addr,
  input  logic [NUM_CLI*DATA_BITS-1:0]   cli_wdata,
  input  logic [NUM_CLI*DATA_BITS/8-1:0] cli_wm,
  output logic [NUM_CLI-1:0]             cli_ack,
  output logic [DATA_BITS-1:0]           cli_rdata,
  output logic [NUM_CLI-1:0]             cli_busy,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [DATA_BITS-1:0]           mem_wdata,
  output logic [DATA_BITS/8-1:0]         mem_wm,
  input  logic                           mem_ack,
  input  logic [DATA_BITS-1:0]           mem_rdata
);

  localparam int unsigned WM_BITS = DATA_BITS / 8;
  localparam int unsigned GW      = $clog2(NUM_CLI);
  localparam int unsigned PW      = 1 << GW;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CLI-1:0]   pending_q, pending_d;
  logic [NUM_CLI-1:0]   slot_we_q, slot_we_d;
  logic [ADDR_BITS-1:0] slot_addr_q  [NUM_CLI];
  logic [ADDR_BITS-1:0] slot_addr_d  [NUM_CLI];
  logic [DATA_BITS-1:0] slot_wdata_q [NUM_CLI];
  logic [DATA_BITS-1:0] slot_wdata_d [NUM_CLI];
  logic [WM_BITS-1:0]   slot_wm_q    [NUM_CLI];
  logic [WM_BITS-1:0]   slot_wm_d    [NUM_CLI];
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [WM_BITS-1:0]   mem_wm_q, mem_wm_d;
  logic [NUM_CLI-1:0]   ack_q, ack_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;

  logic [PW-1:0]        pend_ext;
  logic [GW-1:0]        cand;
  logic [GW-1:0]        sel;
  logic                 sel_valid;
  logic                 done;

  // Next grant: first pending slot after last_q, wrapping around the client range.
  always_comb begin
    pend_ext  = PW'(pending_q);
    cand      = '0;
    sel       = '0;
    sel_valid = 1'b0;
`ifdef SDRAM_ARB_PRIO_EN
    if (pending_q[0]) begin
      sel_valid = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_CLI - 1; k++) begin
        cand = GW'(1 + ((32'(last_q) + k) % (NUM_CLI - 1)));
        if (!sel_valid && pend_ext[cand]) begin
          sel       = cand;
          sel_valid = 1'b1;
        end
      end
    end
`else
    for (int unsigned k = 0; k < NUM_CLI; k++) begin
      cand = GW'((32'(last_q) + 1 + k) % NUM_CLI);
      if (!sel_valid && pend_ext[cand]) begin
        sel       = cand;
        sel_valid = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_wm_d    = slot_wm_q;
    grant_d      = grant_q;
    last_d       = last_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wm_d     = mem_wm_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    done         = (state_q == S_WAIT) && mem_ack;

    // A slot completing on this edge frees up in time to take a new request.
    for (int unsigned i = 0; i < NUM_CLI; i++) begin
      if (done && (grant_q == GW'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (cli_req[i] && (!pending_q[i] || (done && (grant_q == GW'(i))))) begin
        pending_d[i]    = 1'b1;
        slot_we_d[i]    = cli_we[i];
        slot_addr_d[i]  = cli_addr[i*ADDR_BITS +: ADDR_BITS];
        slot_wdata_d[i] = cli_wdata[i*DATA_BITS +: DATA_BITS];
        slot_wm_d[i]    = cli_wm[i*WM_BITS +: WM_BITS];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          mem_req_d = 1'b1;
          grant_d   = sel;
          state_d   = S_WAIT;
          for (int unsigned i = 0; i < NUM_CLI; i++) begin
            if (sel == GW'(i)) begin
              mem_we_d    = slot_we_q[i];
              mem_addr_d  = slot_addr_q[i];
              mem_wdata_d = slot_wdata_q[i];
              mem_wm_d    = slot_wm_q[i];
            end
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          for (int unsigned i = 0; i < NUM_CLI; i++) begin
            if (grant_q == GW'(i)) begin
              ack_d[i] = 1'b1;
            end
          end
          rdata_d = mem_rdata;
`ifdef SDRAM_ARB_PRIO_EN
          if (grant_q != '0) begin
            last_d = grant_q;
          end
`else
          last_d = grant_q;
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      slot_we_q   <= '0;
      for (int unsigned i = 0; i < NUM_CLI; i++) begin
        slot_addr_q[i]  <= '0;
        slot_wdata_q[i] <= '0;
        slot_wm_q[i]    <= '0;
      end
      grant_q     <= '0;
      last_q      <= GW'(NUM_CLI - 1);
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wm_q    <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_wm_q    <= slot_wm_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wm_q     <= mem_wm_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign cli_busy  = pending_q;
  assign cli_ack   = ack_q;
  assign cli_rdata = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wm    = mem_wm_q;

endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Bench for sdram_ch_arbiter: transaction-level reference model plus per-cycle output compare.
module tb_sdram_ch_arbiter;

  localparam int NC = 3;
  localparam int AB = 24;
  localparam int DB = 16;
  localparam int WB = DB / 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NC-1:0]    cli_req = '0;
  logic [NC-1:0]    cli_we = '0;
  logic [NC*AB-1:0] cli_addr = '0;
  logic [NC*DB-1:0] cli_wdata = '0;
  logic [NC*WB-1:0] cli_wm = '0;
  logic [NC-1:0]    cli_ack;
  logic [DB-1:0]    cli_rdata;
  logic [NC-1:0]    cli_busy;
  logic             mem_req;
  logic             mem_we;
  logic [AB-1:0]    mem_addr;
  logic [DB-1:0]    mem_wdata;
  logic [WB-1:0]    mem_wm;
  logic             mem_ack;
  logic [DB-1:0]    mem_rdata;

  // Responder controls: automatic (random delay) or driven by the main sequence.
  logic          auto_ack = 1'b0;
  logic          rsp_fixed_en = 1'b0;
  logic [DB-1:0] rsp_fixed = '0;
  logic          rsp_ack = 1'b0;
  logic [DB-1:0] rsp_rdata = '0;
  logic          man_ack = 1'b0;
  logic [DB-1:0] man_rdata = '0;

  assign mem_ack   = rsp_ack | man_ack;
  assign mem_rdata = auto_ack ? rsp_rdata : man_rdata;

  int checks = 0;
  int errors = 0;
  int ack_cnt [NC];
  int issue_cnt = 0;

  sdram_ch_arbiter #(.NUM_CLI(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr),
    .cli_wdata(cli_wdata), .cli_wm(cli_wm),
    .cli_ack(cli_ack), .cli_rdata(cli_rdata), .cli_busy(cli_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wm(mem_wm),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit            m_pend  [NC];
  bit            m_we    [NC];
  logic [AB-1:0] m_addr  [NC];
  logic [DB-1:0] m_wdata [NC];
  logic [WB-1:0] m_wm    [NC];
  int            m_owner;
  int            m_last;
  logic          m_mem_req;
  logic          m_mwe;
  logic [AB-1:0] m_maddr;
  logic [DB-1:0] m_mwdata;
  logic [WB-1:0] m_mwm;
  logic [NC-1:0] m_ack;
  logic [DB-1:0] m_rdata;
  int            m_log [$];

  function automatic int pick();
`ifdef SDRAM_ARB_PRIO_EN
    if (m_pend[0]) return 0;
    for (int d = 1; d < NC; d++) begin
      int c;
      c = (m_last - 1 + d) % (NC - 1) + 1;
      if (m_pend[c]) return c;
    end
`else
    for (int d = 1; d <= NC; d++) begin
      int c;
      c = (m_last + d) % NC;
      if (m_pend[c]) return c;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        m_pend[i] = 0; m_we[i] = 0; m_addr[i] = '0; m_wdata[i] = '0; m_wm[i] = '0;
      end
      m_owner = -1; m_last = NC - 1;
      m_mem_req = 0; m_mwe = 0; m_maddr = '0; m_mwdata = '0; m_mwm = '0;
      m_ack = '0; m_rdata = '0;
    end else begin
      int comp;
      int g;
      bit cap [NC];
      comp = (m_owner >= 0 && mem_ack) ? m_owner : -1;
      for (int i = 0; i < NC; i++) cap[i] = cli_req[i] && (!m_pend[i] || comp == i);
      m_ack = '0;
      m_mem_req = 0;
      if (m_owner >= 0) begin
        if (mem_ack) begin
          m_ack[m_owner] = 1'b1;
          m_rdata = mem_rdata;
          m_pend[m_owner] = 0;
`ifdef SDRAM_ARB_PRIO_EN
          if (m_owner != 0) m_last = m_owner;
`else
          m_last = m_owner;
`endif
          m_owner = -1;
        end
      end else begin
        g = pick();
        if (g >= 0) begin
          m_mem_req = 1; m_mwe = m_we[g]; m_maddr = m_addr[g];
          m_mwdata = m_wdata[g]; m_mwm = m_wm[g];
          m_owner = g;
          m_log.push_back(g);
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (cap[i]) begin
          m_pend[i] = 1; m_we[i] = cli_we[i];
          m_addr[i] = cli_addr[i*AB +: AB];
          m_wdata[i] = cli_wdata[i*DB +: DB];
          m_wm[i] = cli_wm[i*WB +: WB];
        end
      end
    end
  end

  // ---------------- automatic responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      rsp_ack = 1'b0;
      if (auto_ack && mem_req === 1'b1) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rsp_rdata = rsp_fixed_en ? rsp_fixed : DB'($urandom);
        rsp_ack = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cli(input int i, input bit we, input logic [AB-1:0] a,
                         input logic [DB-1:0] d, input logic [WB-1:0] m);
    cli_we[i] = we;
    cli_addr[i*AB +: AB] = a;
    cli_wdata[i*DB +: DB] = d;
    cli_wm[i*WB +: WB] = m;
  endtask

  task automatic pulse(input logic [NC-1:0] mask);
    cli_req = mask;
    @(negedge clk);
    cli_req = '0;
  endtask

  task automatic wait_mem_req();
    bit ok;
    ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (mem_req === 1'b1) ok = 1;
      else @(negedge clk);
    end
    check("wait_mem_req", ok, 1);
  endtask

  task automatic wait_ack(input int i);
    bit ok;
    ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (cli_ack[i] === 1'b1) ok = 1;
    end
    check("wait_ack", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (cli_busy == '0 && mem_req == 1'b0 && cli_ack == '0) ok = 1;
    end
    check("wait_idle", ok, 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_log(input string name, input int start, input int e[$]);
    int n;
    check({name, "_count"}, m_log.size() - start, e.size());
    n = (m_log.size() - start < e.size()) ? m_log.size() - start : e.size();
    for (int k = 0; k < n; k++) check($sformatf("%s_grant%0d", name, k), m_log[start+k], e[k]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int log0;
    int a0;
    int i0;
    int e[$];
    logic [NC-1:0] pv;
    int mask;

    for (int i = 0; i < NC; i++) ack_cnt[i] = 0;

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < NC; i++) pv[i] = m_pend[i];
        check("cli_busy", cli_busy, pv);
        check("mem_req", mem_req, m_mem_req);
        check("mem_we", mem_we, m_mwe);
        check("mem_addr", mem_addr, m_maddr);
        check("mem_wdata", mem_wdata, m_mwdata);
        check("mem_wm", mem_wm, m_mwm);
        check("cli_ack", cli_ack, m_ack);
        check("cli_rdata", cli_rdata, m_rdata);
        for (int i = 0; i < NC; i++) if (cli_ack[i] === 1'b1) ack_cnt[i]++;
        if (mem_req === 1'b1) issue_cnt++;
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", cli_busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_cli_ack", cli_ack, 0);
    reset = 1'b1;
    @(negedge clk);

    // T1: single write from client 1, manual ack
    set_cli(1, 1'b1, 24'h000010, 16'hBEEF, 2'b00);
    pulse(3'b010);
    check("t1_busy_capture", cli_busy, 3'b010);
    check("t1_no_req_yet", mem_req, 0);
    @(negedge clk);
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 24'h000010);
    check("t1_mem_we", mem_we, 1);
    check("t1_mem_wdata", mem_wdata, 16'hBEEF);
    check("t1_mem_wm", mem_wm, 2'b00);
    man_ack = 1'b1; man_rdata = 16'h0;
    @(negedge clk);
    man_ack = 1'b0;
    check("t1_mem_req_one", mem_req, 0);
    check("t1_cli_ack", cli_ack, 3'b010);
    check("t1_busy_clear", cli_busy, 3'b000);
    @(negedge clk);
    check("t1_cli_ack_one", cli_ack, 3'b000);

    // T2: round-robin ordering
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < NC; i++) set_cli(i, 1'b0, AB'(i * 16), 16'h0, 2'b11);
    log0 = m_log.size();
    pulse(3'b111); wait_idle();
    pulse(3'b111); wait_idle();
    pulse(3'b110); wait_idle();
    pulse(3'b110); wait_mem_req(); pulse(3'b001); wait_idle();
`ifdef SDRAM_ARB_PRIO_EN
    e = '{0, 1, 2, 0, 1, 2, 1, 2, 1, 0, 2};
`else
    e = '{0, 1, 2, 0, 1, 2, 1, 2, 1, 2, 0};
`endif
    check_log("t2", log0, e);

    // T3: read data routing
    rsp_fixed_en = 1'b1; rsp_fixed = 16'h1234;
    set_cli(0, 1'b1, 24'h000100, 16'hA7F8, 2'b11);
    pulse(3'b001); wait_idle();
    rsp_fixed = 16'hF7F8;
    set_cli(2, 1'b0, 24'hFFFFFF, 16'h0, 2'b00);
    pulse(3'b100);
    wait_mem_req();
    check("t3_mem_addr", mem_addr, 24'hFFFFFF);
    check("t3_mem_we", mem_we, 0);
    wait_ack(2);
    check("t3_cli_rdata", cli_rdata, 16'hF7F8);
    wait_idle();
    rsp_fixed_en = 1'b0;

    // T4: dropped re-request and re-capture on the ack edge
    auto_ack = 1'b0;
    a0 = ack_cnt[0]; i0 = issue_cnt;
    set_cli(0, 1'b0, 24'h000001, 16'h0, 2'b00);
    cli_req = 3'b001;
    @(negedge clk);
    set_cli(0, 1'b0, 24'h000002, 16'h0, 2'b00);
    @(negedge clk);
    cli_req = '0;
    check("t4_mem_req", mem_req, 1);
    check("t4_mem_addr1", mem_addr, 24'h000001);
    repeat (2) @(negedge clk);
    set_cli(0, 1'b0, 24'h000003, 16'h0, 2'b00);
    cli_req = 3'b001; man_ack = 1'b1; man_rdata = 16'h5A5A;
    @(negedge clk);
    cli_req = '0; man_ack = 1'b0;
    check("t4_ack1", cli_ack, 3'b001);
    check("t4_recaptured", cli_busy, 3'b001);
    @(negedge clk);
    check("t4_mem_req2", mem_req, 1);
    check("t4_mem_addr3", mem_addr, 24'h000003);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("t4_ack2", cli_ack, 3'b001);
    repeat (2) @(negedge clk);
    check("t4_ack_count", ack_cnt[0] - a0, 2);
    check("t4_issue_count", issue_cnt - i0, 2);

    // T5: reset mid-transaction, stray ack ignored
    set_cli(1, 1'b1, 24'h000055, 16'h1111, 2'b01);
    pulse(3'b010);
    wait_mem_req();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_rst_busy", cli_busy, 0);
    check("t5_rst_mem_req", mem_req, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_mem_wdata", mem_wdata, 0);
    check("t5_rst_cli_rdata", cli_rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    a0 = ack_cnt[1];
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_stray_ack", ack_cnt[1] - a0, 0);
    check("t5_no_stray_req", mem_req, 0);
    auto_ack = 1'b1;
    pulse(3'b010);
    wait_ack(1);
    wait_idle();

    // T6: client 0 re-requests on every ack while 1,2 wait
    do_reset();
    auto_ack = 1'b0;
    log0 = m_log.size();
    pulse(3'b111);
    for (int it = 0; it < 4; it++) begin
      wait_mem_req();
      man_ack = 1'b1;
      if (it < 3) cli_req = 3'b001;
      @(negedge clk);
      man_ack = 1'b0;
      cli_req = '0;
    end
    auto_ack = 1'b1;
    wait_idle();
`ifdef SDRAM_ARB_PRIO_EN
    e = '{0, 0, 0, 0, 1, 2};
`else
    e = '{0, 1, 2, 0};
`endif
    check_log("t6", log0, e);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      mask = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << NC) - 1) : 0;
      for (int i = 0; i < NC; i++)
        if (mask[i]) set_cli(i, 1'($urandom), AB'($urandom), DB'($urandom), WB'($urandom));
      cli_req = NC'(mask);
      @(negedge clk);
    end
    cli_req = '0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
